// File: rtl/sc_fifo_rd_pkg.sv
// Shared types and constants for the generic_sc_fifo read-side stream adapter.
// Latency: n/a (declarations only); backpressure: n/a.
package sc_fifo_rd_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int CNT_W     = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    // Words already buffered plus the one still in flight must leave room for another read.
    function automatic logic has_credit(input cnt_t cnt, input logic inflight);
        logic [2:0] pending;
        pending = {1'b0, cnt} + {2'b00, inflight};
        return pending < 3'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/generic_sc_fifo.sv
// Single-clock FIFO with registered read data and flags derived from registered state.
// Latency: data_o valid one cycle after an accepted read; backpressure: writes ignored when full, reads ignored when empty.
module generic_sc_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CW-1:0]     count;
    logic              do_wr;
    logic              do_rd;

    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;

    // Storage has no reset; only pointers and count define which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            data_o <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                data_o <= mem[rd_ptr];
            end
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/sc_fifo_rd_buf.sv
// Small register queue with simultaneous push/pop and synchronous clear; head is always entry 0.
// Latency: pushed word visible at head next cycle when queue was empty; backpressure: caller must not push when full or pop when empty.
module sc_fifo_rd_buf #(
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_dat_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [DATA_W-1:0] q     [BUF_DEPTH];
    logic [DATA_W-1:0] q_nxt [BUF_DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  wr_idx;

    always_comb begin
        q_nxt   = q;
        wr_idx  = pop_i ? (cnt_q - CNT_W'(1)) : cnt_q;
        cnt_nxt = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        if (pop_i) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                q_nxt[i] = q[i + 1];
            end
            q_nxt[BUF_DEPTH-1] = '0;
        end
        // Tail slot accounts for the shift, so push and pop together keep the count.
        if (push_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    q_nxt[i] = push_dat_i;
                end
            end
        end
        if (clr_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                q_nxt[i] = '0;
            end
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            q     <= q_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    assign head_dat_o = q[0];
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/sc_fifo_stream_reader.sv
// Drains a generic_sc_fifo read port into a valid/ready stream at one word per clock.
// Latency: 2 cycles from FIFO non-empty to valid_o; backpressure: reads stop once buffered plus in-flight words reach 3, ready_i never reaches fifo_rd_en_o combinationally.
module sc_fifo_stream_reader
    import sc_fifo_rd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              fifo_rd_en_o,
    input  logic [DATA_W-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [1:0]        used_o
);

    cnt_t cnt;
    logic inflight;
    logic rd_en;
    logic pop;
    logic push;

    assign rd_en = !rst_i && !flush_i && !fifo_empty_i && has_credit(cnt, inflight);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
        end
    end

    // A word landing during flush belongs to the discarded stream and is dropped.
    assign push = inflight && !flush_i;
    assign pop  = valid_o && ready_i;

    sc_fifo_rd_buf #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) u_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (flush_i),
        .push_i     (push),
        .push_dat_i (fifo_data_i),
        .pop_i      (pop),
        .head_dat_o (data_o),
        .cnt_o      (cnt)
    );

    assign valid_o      = (cnt != '0);
    assign used_o       = cnt;
    assign fifo_rd_en_o = rd_en;

endmodule

// File: tb/tb_sc_fifo_stream_reader.sv
// Directed bench: real generic_sc_fifo in front of the reader, consumer driven per cycle.
// Inputs change 1 time unit after the rising edge; registered outputs are sampled there too.
module tb_sc_fifo_stream_reader;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_dat;
    logic              rd_en;
    logic [DATA_W-1:0] fifo_dat;
    logic              empty;
    logic              full;
    logic              flush;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic [1:0]        used;

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] w [31];

    always #5 clk = ~clk;

    generic_sc_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
        .clk_i   (clk),
        .rst_i   (fifo_rst),
        .wr_en_i (wr_en),
        .data_i  (wr_dat),
        .rd_en_i (rd_en),
        .data_o  (fifo_dat),
        .empty_o (empty),
        .full_o  (full)
    );

    sc_fifo_stream_reader #(.DATA_W(DATA_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fifo_rd_en_o (rd_en),
        .fifo_data_i  (fifo_dat),
        .fifo_empty_i (empty),
        .flush_i      (flush),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .used_o       (used)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unique low bits keep duplicates and drops visible in the ordering checks.
    task automatic gen_words();
        for (int i = 0; i < 31; i++) begin
            w[i] = {3'($urandom), 5'(i)};
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; fifo_rst = 1'b1; wr_en = 1'b0; wr_dat = '0; flush = 1'b0; ready = 1'b0;
        #12;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
        checks++; if (used !== 2'd0) begin failures++; $display("FAIL reset_used got=%0d exp=0", used); end
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
        @(negedge clk);
        rst = 1'b0; fifo_rst = 1'b0;
        tick();
        checks++; if (valid !== 1'b0 || used !== 2'd0) begin failures++; $display("FAIL idle_state got valid=%b used=%0d exp valid=0 used=0", valid, used); end
        checks++; if (rd_en !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL idle_rd_en got rd_en=%b full=%b exp 0 0", rd_en, full); end
    endtask

    task automatic test_stream();
        int got = 0;
        int n_wr = 0;
        int first_ne = -1;
        int first_vld = -1;
        int over = 0;
        gen_words();
        ready = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 31; cyc++) begin
            tick();
            if (!empty && first_ne < 0) first_ne = cyc;
            if (used > 2'd2) over++;
            if (got > 0) begin
                checks++; if (valid !== 1'b1) begin failures++; $display("FAIL stream_gap word=%0d got valid=%b exp=1", got, valid); end
            end
            if (valid) begin
                if (first_vld < 0) first_vld = cyc;
                checks++; if (data !== w[got]) begin failures++; $display("FAIL stream_data word=%0d got=%h exp=%h", got, data, w[got]); end
                got++;
            end
            wr_en = (n_wr < 31);
            if (n_wr < 31) begin wr_dat = w[n_wr]; n_wr++; end
        end
        wr_en = 1'b0;
        checks++; if (got !== 31) begin failures++; $display("FAIL stream_count got=%0d exp=31", got); end
        checks++; if (first_vld - first_ne !== 2) begin failures++; $display("FAIL stream_latency got=%0d exp=2", first_vld - first_ne); end
        checks++; if (over !== 0) begin failures++; $display("FAIL stream_used_over2 got=%0d cycles exp=0", over); end
        repeat (4) tick();
    endtask

    task automatic test_stall();
        int reads = 0;
        int n_wr = 0;
        int got = 0;
        logic seen = 1'b0;
        gen_words();
        ready = 1'b0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            tick();
            if (seen) begin
                checks++; if (valid !== 1'b1 || data !== w[0]) begin failures++; $display("FAIL stall_hold got valid=%b data=%h exp valid=1 data=%h", valid, data, w[0]); end
            end
            if (valid) seen = 1'b1;
            wr_en = (n_wr < 31);
            if (n_wr < 31) begin wr_dat = w[n_wr]; n_wr++; end
            #1;
            if (rd_en) reads++;
        end
        wr_en = 1'b0;
        checks++; if (reads !== 3) begin failures++; $display("FAIL stall_reads got=%0d exp=3", reads); end
        checks++; if (used !== 2'd3) begin failures++; $display("FAIL stall_used got=%0d exp=3", used); end
        ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 31; cyc++) begin
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL drain_gap word=%0d got valid=%b exp=1", got, valid); end
            if (valid) begin
                checks++; if (data !== w[got]) begin failures++; $display("FAIL drain_data word=%0d got=%h exp=%h", got, data, w[got]); end
                got++;
            end
            tick();
        end
        checks++; if (got !== 31) begin failures++; $display("FAIL drain_count got=%0d exp=31", got); end
        repeat (4) tick();
    endtask

    task automatic test_toggle();
        int got = 0;
        int n_wr = 0;
        logic stall = 1'b0;
        logic [DATA_W-1:0] held = '0;
        gen_words();
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            tick();
            if (stall) begin
                checks++; if (valid !== 1'b1 || data !== held) begin failures++; $display("FAIL toggle_hold got valid=%b data=%h exp valid=1 data=%h", valid, data, held); end
            end
            ready = ((cyc % 2) == 1);
            if (valid && ready) begin
                checks++; if (data !== w[got]) begin failures++; $display("FAIL toggle_data word=%0d got=%h exp=%h", got, data, w[got]); end
                got++;
            end
            stall = valid && !ready;
            held  = data;
            wr_en = (n_wr < 20);
            if (n_wr < 20) begin wr_dat = w[n_wr]; n_wr++; end
        end
        wr_en = 1'b0;
        ready = 1'b1;
        checks++; if (got !== 20) begin failures++; $display("FAIL toggle_count got=%0d exp=20", got); end
        repeat (4) tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL toggle_extra got valid=%b exp=0", valid); end
    endtask

    task automatic test_gap();
        int vi [3];
        int exp_vi [3];
        int got = 0;
        exp_vi[0] = 3; exp_vi[1] = 9; exp_vi[2] = 10;
        gen_words();
        ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            if (valid && got < 3) begin
                checks++; if (data !== w[got]) begin failures++; $display("FAIL gap_data word=%0d got=%h exp=%h", got, data, w[got]); end
                vi[got] = cyc;
                got++;
            end
            wr_en  = (cyc == 0 || cyc == 6 || cyc == 7);
            wr_dat = (cyc == 0) ? w[0] : (cyc == 6) ? w[1] : w[2];
            #1;
            checks++; if (rd_en === 1'b1 && empty === 1'b1) begin failures++; $display("FAIL gap_rd_while_empty cyc=%0d got rd_en=1 exp=0", cyc); end
        end
        wr_en = 1'b0;
        checks++; if (got !== 3) begin failures++; $display("FAIL gap_count got=%0d exp=3", got); end
        for (int i = 0; i < 3; i++) begin
            if (i < got) begin
                checks++; if (vi[i] !== exp_vi[i]) begin failures++; $display("FAIL gap_timing word=%0d got cyc=%0d exp=%0d", i, vi[i], exp_vi[i]); end
            end
        end
    endtask

    task automatic test_flush();
        int got = 0;
        gen_words();
        flush = 1'b1;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            wr_en = 1'b1; wr_dat = w[i];
            #1;
            checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL flush_hold_rd_en i=%0d got=%b exp=0", i, rd_en); end
        end
        tick();
        wr_en = 1'b0; flush = 1'b0;
        repeat (3) tick();
        checks++; if (used !== 2'd2 || data !== w[0]) begin failures++; $display("FAIL flush_setup got used=%0d data=%h exp used=2 data=%h", used, data, w[0]); end
        flush = 1'b1;
        #1;
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL flush_rd_en got=%b exp=0", rd_en); end
        tick();
        checks++; if (used !== 2'd0 || valid !== 1'b0) begin failures++; $display("FAIL flush_clear got used=%0d valid=%b exp 0 0", used, valid); end
        flush = 1'b0; ready = 1'b1;
        for (int cyc = 0; cyc < 12 && got < 2; cyc++) begin
            tick();
            if (valid) begin
                checks++; if (data !== w[3 + got]) begin failures++; $display("FAIL flush_next word=%0d got=%h exp=%h", got, data, w[3 + got]); end
                got++;
            end
        end
        checks++; if (got !== 2) begin failures++; $display("FAIL flush_count got=%0d exp=2", got); end
        repeat (3) tick();
        checks++; if (valid !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL flush_tail got valid=%b empty=%b exp 0 1", valid, empty); end
    endtask

    task automatic test_async_reset();
        int got = 0;
        gen_words();
        flush = 1'b1; ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            wr_en = 1'b1; wr_dat = w[i];
        end
        tick();
        wr_en = 1'b0; flush = 1'b0; ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid !== 1'b1 || data !== w[i]) begin failures++; $display("FAIL rst_pre word=%0d got valid=%b data=%h exp valid=1 data=%h", i, valid, data, w[i]); end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (valid !== 1'b0 || data !== 8'h00 || used !== 2'd0) begin failures++; $display("FAIL rst_async got valid=%b data=%h used=%0d exp 0 00 0", valid, data, used); end
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL rst_async_rd_en got=%b exp=0", rd_en); end
        tick();
        checks++; if (rd_en !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL rst_held got rd_en=%b valid=%b exp 0 0", rd_en, valid); end
        rst = 1'b0;
        for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
            tick();
            if (valid) begin
                checks++; if (data !== w[4 + got]) begin failures++; $display("FAIL rst_restart word=%0d got=%h exp=%h", got, data, w[4 + got]); end
                got++;
            end
        end
        checks++; if (got !== 6) begin failures++; $display("FAIL rst_restart_count got=%0d exp=6", got); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_toggle();
        test_gap();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sc_fifo_stream_reader.md
# sc_fifo_stream_reader

Read-side adapter for `generic_sc_fifo`. It drains the FIFO's `rd_en`/`data_o` port and presents the words as a valid/ready stream source. A 3-entry output buffer hides the FIFO's one-cycle registered read latency, so the block sustains one word per clock. `ready_i` has no combinational path to `fifo_rd_en_o`. It sits between any `generic_sc_fifo` instance and a downstream stream consumer in the same clock domain.

## Interface
- `DATA_W`, default 8: word width; must match the attached FIFO.
- `clk_i`  in  1  system clock, all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `fifo_rd_en_o`  out  1  read request to FIFO `rd_en_i`.
- `fifo_data_i`  in  DATA_W  FIFO `data_o`; valid exactly one cycle after an accepted read.
- `fifo_empty_i`  in  1  FIFO `empty_o`.
- `flush_i`  in  1  synchronous discard of all buffered and in-flight words.
- `data_o`  out  DATA_W  stream data, head of output buffer.
- `valid_o`  out  1  stream valid.
- `ready_i`  in  1  stream ready from the consumer.
- `used_o`  out  2  output buffer occupancy, 0..3.

## Operation
- State:
  - 3-entry register queue `buf[0..2]` with occupancy `cnt` (0..3).
  - `inflight` flag: a read was issued last cycle, so data arrives this cycle.
- `fifo_rd_en_o = !rst_i && !flush_i && !fifo_empty_i && (cnt + inflight) < 3`.
  - Depends on registered state only, plus `fifo_empty_i` and `flush_i`.
- `inflight` is set on every cycle where `fifo_rd_en_o` = 1; it is cleared otherwise.
- Each cycle, with `pop = valid_o && ready_i` and `push = inflight && !flush_i`:
  - `push`: `fifo_data_i` is appended at tail.
  - `pop`: head is removed.
  - Both: the queue shifts and appends in the same cycle, and `cnt` is unchanged.
- Width rule: `cnt + inflight` is evaluated 3 bits wide; `cnt` can never exceed 3, which is guaranteed by the credit rule.
- `valid_o = (cnt != 0)`; `data_o = buf[0]`.
- `used_o = cnt`.
- Stream rules:
  - Once `valid_o` = 1 and `ready_i` = 0, `valid_o` and `data_o` hold stable until accepted (no retraction) unless `flush_i`.
  - Word order equals FIFO order, with no loss and no duplication.
- `flush_i` = 1 for one cycle:
  - Next cycle `cnt` = 0 and `inflight` = 0.
  - A word arriving from a read issued in the previous cycle is dropped.
  - `fifo_rd_en_o` = 0 during the flush cycle.
  - A `pop` coinciding with flush still counts as consumed by the downstream side.
  - The FIFO contents are not affected.
- `fifo_empty_i` = 1: no read is issued, and buffered words continue to drain.
- `ready_i` held low: at most 3 words are read out of the FIFO, then `fifo_rd_en_o` stays 0.

## Timing
- Reset values: `valid_o` = 0, `data_o` = 0, `used_o` = 0, `fifo_rd_en_o` = 0, `inflight` = 0, buffer cleared.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronously).
  - An in-flight word is lost; buffered words are lost.
  - `fifo_rd_en_o` is forced low for as long as `rst_i` is high.
- Latency: the FIFO going non-empty (empty = 0 sampled at edge N, cnt = 0) gives read at edge N, `valid_o` = 1 after edge N+1. First-word latency is 2 cycles from `empty_i` falling to `valid_o`.
- Throughput: 1 word/cycle with `ready_i` = 1 and the FIFO non-empty. In steady state `cnt` = 1 and `inflight` = 1.
- A stall release (`ready_i` 0→1) with `cnt` = 3 yields 3 back-to-back words. FIFO reads resume on the first cycle where `cnt + inflight` < 3.

## Structure
- Shared package `sc_fifo_rd_pkg`:
  - `BUF_DEPTH` = 3.
  - `CNT_W` = 2.
  - `cnt_t` typedef.
- One sub-module, `sc_fifo_rd_buf`: parameterised `DATA_W`/`BUF_DEPTH` register queue with push/pop/clear and count output.
- The top level holds the credit logic, the `inflight` flag and flush handling.

## Test plan
- Fill the FIFO (ADDR_W = 5) with 31 random words, `ready_i` = 1 throughout → 31 words out in order on consecutive cycles after a 2-cycle start latency, `used_o` never > 2.
- Same 31 words with `ready_i` = 0 → exactly 3 FIFO reads, `used_o` = 3, `valid_o` held with `data_o` = word 0 stable. Release `ready_i` → remaining 31 words in order, none lost.
- `ready_i` toggling 1/0 every cycle over 20 words → 20 words in order, no duplicates, `data_o` stable while stalled.
- FIFO holds 1 word, then is empty for 5 cycles, then 2 words arrive → output word0, gap, word1, word2. `fifo_rd_en_o` is never high while `fifo_empty_i` = 1.
- `flush_i` pulse in the cycle after a read is issued, with `cnt` = 2 → next cycle `used_o` = 0, `valid_o` = 0, the in-flight word is discarded, and the next output is the following FIFO word.
- `rst_i` asserted asynchronously mid-burst (between edges) → outputs are immediately 0 and `fifo_rd_en_o` is 0. After release, the stream restarts with the next word in the FIFO.
